// File: rtl/better_and_gate.sv
// Two-input AND gate with a combinational output plus a registered copy,
// rise/fall event pulses and saturating activity counters.
module better_and_gate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             out,
  output logic             out_q,
  output logic             out_rise,
  output logic             out_fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] edge_cnt
);

  logic             n;
  logic             changed;
  logic             high_sat;
  logic             edge_sat;
  logic [CNT_W-1:0] high_cnt_nxt;
  logic [CNT_W-1:0] edge_cnt_nxt;

  assign n   = a & b;
  assign out = n;

  assign changed  = n ^ out_q;
  assign high_sat = &high_cnt;
  assign edge_sat = &edge_cnt;

  // Counters hold at all-ones rather than wrapping back to zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    high_cnt_nxt = high_cnt;
    edge_cnt_nxt = edge_cnt;
    if (clr) begin
      high_cnt_nxt = '0;
      edge_cnt_nxt = '0;
    end else begin
      if (out_q && !high_sat)
        high_cnt_nxt = high_cnt + 1'b1;
      if (changed && !edge_sat)
        edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  // Reset outranks clr; clr only ever touches the counters.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_q    <= 1'b0;
      out_rise <= 1'b0;
      out_fall <= 1'b0;
      high_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      out_q    <= n;
      out_rise <= n & ~out_q;
      out_fall <= ~n & out_q;
      high_cnt <= high_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_better_and_gate.sv
// Directed self-checking bench for better_and_gate: default-width instance plus
// a CNT_W=2 instance sharing the same stimulus to exercise saturation.
module tb_better_and_gate;

  localparam int W  = 16;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          run = 1'b0;
  logic          rst, a, b, clr;
  logic          out, out_q, out_rise, out_fall;
  logic [W-1:0]  high_cnt, edge_cnt;
  logic          s_out, s_out_q, s_out_rise, s_out_fall;
  logic [WS-1:0] s_high_cnt, s_edge_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rise_seen, fall_seen;

  better_and_gate #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .out(out), .out_q(out_q), .out_rise(out_rise), .out_fall(out_fall),
    .high_cnt(high_cnt), .edge_cnt(edge_cnt)
  );

  better_and_gate #(.CNT_W(WS)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .out(s_out), .out_q(s_out_q), .out_rise(s_out_rise), .out_fall(s_out_fall),
    .high_cnt(s_high_cnt), .edge_cnt(s_edge_cnt)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sweep_ab [8];
  logic       sweep_out [8];

  initial begin
    sweep_ab  = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    sweep_out = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;

    // Combinational sweep with the clock idle.
    for (int i = 0; i < 8; i++) begin
      a = sweep_ab[i][1];
      b = sweep_ab[i][0];
      #10;
      check($sformatf("sweep%0d_out", i), {31'd0, out}, {31'd0, sweep_out[i]});
    end

    // Reset held for two edges with a = b = 1.
    #3;
    run = 1'b1;
    a = 1'b1; b = 1'b1;
    tick();
    tick();
    check("rst_out",      {31'd0, out},      32'd1);
    check("rst_out_q",    {31'd0, out_q},    32'd0);
    check("rst_rise",     {31'd0, out_rise}, 32'd0);
    check("rst_fall",     {31'd0, out_fall}, 32'd0);
    check("rst_high_cnt", 32'(high_cnt),     32'd0);
    check("rst_edge_cnt", 32'(edge_cnt),     32'd0);

    // Release: first edge with a = b = 1 is edge 1 of 5.
    rst = 1'b0;
    rise_seen = 0; fall_seen = 0;
    tick();
    rise_seen += int'(out_rise); fall_seen += int'(out_fall);
    check("rel_out_q",    {31'd0, out_q},    32'd1);
    check("rel_rise",     {31'd0, out_rise}, 32'd1);
    check("rel_edge_cnt", 32'(edge_cnt),     32'd1);
    check("rel_high_cnt", 32'(high_cnt),     32'd0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      rise_seen += int'(out_rise); fall_seen += int'(out_fall);
      check($sformatf("hold%0d_high_cnt", k), 32'(high_cnt), 32'(k - 1));
    end
    b = 1'b0;
    tick();
    rise_seen += int'(out_rise); fall_seen += int'(out_fall);
    check("drop_out_q", {31'd0, out_q},    32'd0);
    check("drop_fall",  {31'd0, out_fall}, 32'd1);
    tick();
    rise_seen += int'(out_rise); fall_seen += int'(out_fall);
    check("pulse_rise_cycles", 32'(rise_seen), 32'd1);
    check("pulse_fall_cycles", 32'(fall_seen), 32'd1);
    check("after_high_cnt",    32'(high_cnt),  32'd5);
    check("after_edge_cnt",    32'(edge_cnt),  32'd2);
    check("after_s_high_cnt",  32'(s_high_cnt), 32'd3);

    // clr priority: bring out_q back to 1, then clear for one edge.
    b = 1'b1;
    tick();
    check("pre_clr_out_q", {31'd0, out_q}, 32'd1);
    check("pre_clr_edge",  32'(edge_cnt),  32'd3);
    clr = 1'b1;
    tick();
    check("clr_high_cnt", 32'(high_cnt),     32'd0);
    check("clr_edge_cnt", 32'(edge_cnt),     32'd0);
    check("clr_out_q",    {31'd0, out_q},    32'd1);
    check("clr_rise",     {31'd0, out_rise}, 32'd0);
    clr = 1'b0;
    tick();
    check("resume_high_cnt", 32'(high_cnt), 32'd1);
    check("resume_edge_cnt", 32'(edge_cnt), 32'd0);

    // Saturation: fresh reset, then a = b = 1 for 6 edges.
    rst = 1'b1;
    tick();
    check("sat_rst_s_high", 32'(s_high_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) check("sat4_s_high", 32'(s_high_cnt), 32'd3);
    end
    check("sat6_s_high", 32'(s_high_cnt), 32'd3);
    check("sat6_high",   32'(high_cnt),   32'd5);
    check("sat6_s_edge", 32'(s_edge_cnt), 32'd1);

    // Toggle b every edge for 8 edges with a = 1, counters cleared first.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      b = (k % 2 == 0);
      tick();
      check($sformatf("tog%0d_rise", k), {31'd0, out_rise}, {31'd0, (k % 2 == 0)});
      check($sformatf("tog%0d_fall", k), {31'd0, out_fall}, {31'd0, (k % 2 == 1)});
      check($sformatf("tog%0d_overlap", k), {31'd0, out_rise & out_fall}, 32'd0);
    end
    check("tog_edge_cnt",   32'(edge_cnt),   32'd8);
    check("tog_s_edge_cnt", 32'(s_edge_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/better_and_gate.md
# better_and_gate

Two-input AND gate with a zero-latency combinational output and a clocked observation path. The clocked path provides a registered copy of the AND result, single-cycle rise/fall event pulses, and saturating activity counters. It is a leaf cell used wherever a gated enable is needed and its activity must be monitored. The clocked path is synchronous to one clock with a synchronous, active-high reset.

## Interface
- CNT_W, default 16: width of both activity counters, legal range 2..32.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  AND operand A.
- b  input  1  AND operand B.
- clr  input  1  synchronous counter clear; affects only the counters.
- out  output  1  combinational a & b.
- out_q  output  1  a & b registered.
- out_rise  output  1  one-cycle pulse on an out_q 0→1 transition.
- out_fall  output  1  one-cycle pulse on an out_q 1→0 transition.
- high_cnt  output  CNT_W  saturating count of edges where out_q = 1.
- edge_cnt  output  CNT_W  saturating count of out_q transitions.

## Operation
- out = a & b, purely combinational at all times.
  - Independent of clk, rst and clr.
  - Truth table: 00→0, 01→0, 10→0, 11→1.
- At each rising clk edge, with n = a & b sampled at that edge:
  - rst = 1: out_q, out_rise, out_fall, high_cnt and edge_cnt all become 0.
  - otherwise:
    - out_q ← n.
    - out_rise ← n & ~out_q.
    - out_fall ← ~n & out_q.
    - if clr = 1: high_cnt ← 0 and edge_cnt ← 0.
    - else:
      - high_cnt ← high_cnt + 1 if out_q = 1 and high_cnt < 2^CNT_W−1; otherwise it holds.
      - edge_cnt ← edge_cnt + 1 if n ≠ out_q and edge_cnt < 2^CNT_W−1; otherwise it holds.
- Priority: rst > clr > counting.
  - clr does not affect out_q or the pulse outputs.
- Counters saturate at all-ones and never wrap.
- out_rise and out_fall are never both 1 in the same cycle.

## Timing
- out: zero-cycle latency; follows a and b through gate delay only.
- out_q, out_rise, out_fall: one-cycle latency from a/b sampled at an edge.
  - out_rise is high in the first cycle out_q is 1.
  - out_fall is high in the first cycle out_q is 0 after being 1.
- high_cnt: reflects the out_q value of the previous cycle.
  - It lags out_q by one edge.
- edge_cnt: updates on the same edge that out_q changes.
- Reset mid-operation:
  - All registered outputs read 0 in the cycle after the reset edge.
  - out stays live throughout reset.
  - First edge after rst deasserts with a = b = 1: out_rise = 1, since out_q was 0.
- a or b changing between edges: out follows immediately; registered outputs see only the value present at the edge.
- No handshake; no input is ever back-pressured.

## Test plan
- Combinational sweep, clk idle, 10 ns per step, (a,b) sequence 00,10,11,01,00,10,00,01 → out = 0,0,1,0,0,0,0,0.
- Reset:
  - Hold rst = 1 with a = b = 1 for 2 edges → out = 1; out_q = out_rise = out_fall = 0; high_cnt = edge_cnt = 0.
  - Release rst → next edge gives out_q = 1, out_rise = 1, edge_cnt = 1.
- Pulses and counts:
  - a = b = 1 for 5 edges then b = 0 → out_rise high exactly 1 cycle, out_fall high exactly 1 cycle.
  - Afterwards high_cnt = 5, edge_cnt = 2.
- clr priority:
  - Assert clr for one edge while out_q = 1 → both counters read 0 next cycle; out_q stays 1.
  - Counting resumes on the following edge: high_cnt = 1.
- Saturation: CNT_W = 2, a = b = 1 for 6 edges → high_cnt stops at 3, no wrap to 0.
- Toggle: toggle b every edge for 8 edges with a = 1 → edge_cnt = 8; out_rise and out_fall alternate and never overlap.
